mod_split_multi_chan_pipe: RTL and testbench
============================================

# mod_split_multi_chan_pipe

Parametrised multi-channel successor to the single-stage split-variable register block. Each accepted input sample fans out to NCH channels:
- channel 0 saturates to all-ones above a threshold;
- channel i carries data_in + i.

Results pass through a two-stage valid/ready pipeline with backpressure. The block sits in the V3SplitAs isolated test set as the next-generation stress case for split/multi-variable register handling.

## Interface
Parameters:
- WIDTH, 8, sample and per-channel width in bits (>=2)
- NCH, 3, channel count (>=1)
- THRESH, 100, unsigned override threshold for channel 0 (must fit in WIDTH bits)
- CNT_W, 8, width of override counter

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  data_in valid
- in_ready  output  1  block accepts data this cycle
- data_in  input  WIDTH  unsigned input sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- ovr_count  output  CNT_W  saturating count of overridden accepted samples

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
- Stage 1 (s1_valid, s1_data) on adv:
  - s1_valid <= in_valid.
  - If in_valid, s1_data is loaded as follows.
  - ch0 = (data_in > THRESH) ? all-ones : data_in. The comparison is strictly greater than and unsigned.
  - ch i (i>=1) = (data_in + i) mod 2^WIDTH. Wrap-around is silent.
  - If !in_valid, s1_data holds its old value; downstream ignores it.
- Stage 2 (out_valid, out_data) on adv: out_valid <= s1_valid, and out_data <= s1_data when s1_valid.
- Stall: when !adv, both stages hold their contents exactly, and in_valid/data_in are ignored (no acceptance).
- Override counter: increments by 1 when in_valid && in_ready && data_in > THRESH. It saturates at 2^CNT_W-1 and never wraps.
- Reset (asynchronous, any time, including mid-stream): s1_valid=0, s1_data=0, out_valid=0, out_data=0, ovr_count=0. In-flight samples are discarded. The first acceptance after reset deasserts is possible on the next rising edge, since in_ready=1 because out_valid=0.
- NCH=1: only channel 0 exists, with override behaviour.

## Timing
- Latency: a sample accepted at edge N appears on out_data with out_valid=1 after edge N+1, provided there is no stall in between.
- Throughput: 1 sample/cycle while out_ready=1.
- in_ready depends combinationally on out_valid and out_ready only. There is no path from in_valid to in_ready.
- Bubbles (in_valid=0 beats) propagate as out_valid=0 and are collapsed only when the output is empty.
- out_data and out_valid remain stable while out_valid && !out_ready.
- Counter update happens on the same edge as acceptance and is visible the cycle after.

## Configuration
- Macro SPLIT_MULTI_CHAN_OVR_COUNT_EN.
- Defined: ovr_count is implemented as described.
- Undefined: the counter register is not built. ovr_count is tied to constant 0 and the port remains present so bench wiring is unchanged.

## Test plan
- Reset then stream 10, 100, 101, 255 with out_ready=1 (defaults). Expected after 2-cycle latency:
  - 10 -> ch0=0x0A, ch1=0x0B, ch2=0x0C
  - 100 -> ch0=0x64, ch1=0x65, ch2=0x66
  - 101 -> ch0=0xFF, ch1=0x66, ch2=0x67
  - 255 -> ch0=0xFF, ch1=0x00, ch2=0x01
  - ovr_count=2 with macro, 0 without.
- Backpressure: send 5, 6, 7 back-to-back, drop out_ready for 3 cycles after the first output.
  - out_data holds ch0=5 and in_ready=0 for those cycles.
  - Order 5, 6, 7 is preserved with no loss or duplication.
- Bubbles: in_valid pattern 1,0,1 with data 20,X,30 -> out_valid pattern 1,0,1 carrying ch0=20 then 30.
- Reset mid-stream: assert reset asynchronously, between edges, with two samples in flight.
  - out_valid=0, out_data=0 and ovr_count=0 immediately.
  - After release, sample 42 emerges 2 cycles after acceptance.
- Saturation: CNT_W=2, feed six samples of 200 -> ovr_count reads 1, 2, 3, 3, 3, 3.
- Parameter sweep: WIDTH=4, NCH=5, THRESH=9, input 15.
  - Expected: ch0=0xF, ch1=0x0, ch2=0x1, ch3=0x2, ch4=0x3.
  - Input 9: ch0=9.

Source files
------------

// File: rtl/mod_split_multi_chan_pipe.sv
// mod_split_multi_chan_pipe: each accepted sample fans out to NCH channels
// (ch0 saturates to all-ones above THRESH, ch i = data_in + i), then flows
// through a two-stage valid/ready pipeline with a single global advance.
// Optional override counter guarded by macro SPLIT_MULTI_CHAN_OVR_COUNT_EN;
// when undefined, ovr_count is tied to zero.
module mod_split_multi_chan_pipe #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 3,
    parameter int THRESH = 100,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]       ovr_count
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

    logic                       adv;
    logic                       ovr;
    logic [NCH-1:0][WIDTH-1:0]  s1_data_d;
    logic [NCH-1:0][WIDTH-1:0]  s1_data_q;
    logic                       s1_valid_q;
    logic [NCH-1:0][WIDTH-1:0]  out_data_q;
    logic                       out_valid_q;

    // Both stages move together; anything short of a held output lets data flow.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign ovr      = data_in > THR;

    // Per-channel transform of the incoming sample.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        if (i == 0) begin : g_ovr
            assign s1_data_d[i] = ovr ? '1 : data_in;
        end else begin : g_add
            assign s1_data_d[i] = data_in + WIDTH'(i);
        end
    end

    // Stage 1: capture the fanned-out sample; payload only loads on a valid beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_data_q <= s1_data_d;
        end
    end

    // Stage 2: output register, frozen while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_data_q <= s1_data_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SPLIT_MULTI_CHAN_OVR_COUNT_EN
    logic [CNT_W-1:0] ovr_cnt_q;

    // Count accepted over-threshold samples, sticking at the maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else if (in_valid && adv && ovr && (ovr_cnt_q != '1)) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign ovr_count = ovr_cnt_q;
`else
    assign ovr_count = '0;
`endif

endmodule

// File: tb/tb_mod_split_multi_chan_pipe.sv
// Directed bench for mod_split_multi_chan_pipe: default instance plus a
// CNT_W=2 instance for counter saturation and a WIDTH=4/NCH=5 instance.
module tb_mod_split_multi_chan_pipe;

`ifdef SPLIT_MULTI_CHAN_OVR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  data_in;
    logic [23:0] out_data;
    logic [7:0]  ovr_count;

    // saturation instance
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [7:0]  data_in_s;
    logic [23:0] out_data_s;
    logic [1:0]  ovr_count_s;

    // narrow/wide-channel instance
    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [3:0]  data_in_w;
    logic [19:0] out_data_w;
    logic [7:0]  ovr_count_w;

    int ntests = 0;
    int nfail  = 0;

    mod_split_multi_chan_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .ovr_count(ovr_count)
    );

    mod_split_multi_chan_pipe #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .data_in(data_in_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_data(out_data_s), .ovr_count(ovr_count_s)
    );

    mod_split_multi_chan_pipe #(.WIDTH(4), .NCH(5), .THRESH(9)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .data_in(data_in_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_data(out_data_w), .ovr_count(ovr_count_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; data_in = 0; out_ready = 1;
        in_valid_s = 0; data_in_s = 0; out_ready_s = 1;
        in_valid_w = 0; data_in_w = 0; out_ready_w = 1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovr", ovr_count, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // stream 10,100,101,255
        in_valid = 1; data_in = 8'd10;  step();
        chk("str_lat", out_valid, 0);
        data_in = 8'd100; step();
        chk("str_v10", out_valid, 1);
        chk("str_d10", out_data, 24'h0C0B0A);
        data_in = 8'd101; step();
        chk("str_d100", out_data, 24'h666564);
        data_in = 8'd255; step();
        chk("str_d101", out_data, 24'h6766FF);
        in_valid = 0; step();
        chk("str_d255", out_data, 24'h0100FF);
        chk("str_ovr", ovr_count, CNT_ON ? 2 : 0);
        step();
        chk("str_drain", out_valid, 0);

        // backpressure 5,6,7
        in_valid = 1; data_in = 8'd5; step();
        data_in = 8'd6; step();
        chk("bp_d5", out_data[7:0], 5);
        out_ready = 0; data_in = 8'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_hold_v", out_valid, 1);
            chk("bp_hold_d", out_data[7:0], 5);
        end
        out_ready = 1; #1;
        chk("bp_in_ready_rel", in_ready, 1);
        step();
        chk("bp_d6", out_data[7:0], 6);
        in_valid = 0; step();
        chk("bp_v7", out_valid, 1);
        chk("bp_d7", out_data, 24'h090807);
        step();
        chk("bp_nodup", out_valid, 0);

        // bubbles
        in_valid = 1; data_in = 8'd20; step();
        in_valid = 0; data_in = 8'd99; step();
        chk("bub_v1", out_valid, 1);
        chk("bub_d20", out_data[7:0], 20);
        in_valid = 1; data_in = 8'd30; step();
        chk("bub_v0", out_valid, 0);
        in_valid = 0; step();
        chk("bub_v2", out_valid, 1);
        chk("bub_d30", out_data[7:0], 30);
        step();
        chk("bub_end", out_valid, 0);

        // reset mid-stream with two samples in flight
        in_valid = 1; data_in = 8'd200; step();
        data_in = 8'd60; step();
        #2 reset = 1'b1;
        #1;
        chk("mrst_v", out_valid, 0);
        chk("mrst_d", out_data, 0);
        chk("mrst_ovr", ovr_count, 0);
        data_in = 8'd42;
        @(negedge clk); reset = 1'b0;
        step();
        chk("mrst_lat", out_valid, 0);
        in_valid = 0; step();
        chk("mrst_v42", out_valid, 1);
        chk("mrst_d42", out_data, 24'h2C2B2A);
        step();
        chk("mrst_end", out_valid, 0);

        // counter saturation with CNT_W=2
        in_valid_s = 1; data_in_s = 8'd200;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("sat_cnt", ovr_count_s, CNT_ON ? ((k < 3) ? k + 1 : 3) : 0);
        end
        in_valid_s = 0;

        // WIDTH=4, NCH=5, THRESH=9
        in_valid_w = 1; data_in_w = 4'd15; step();
        data_in_w = 4'd9; step();
        chk("sw_d15", out_data_w, 20'h3210F);
        in_valid_w = 0; step();
        chk("sw_d9", out_data_w, 20'hDCBA9);
        chk("sw_ovr", ovr_count_w, CNT_ON ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
